// File: rtl/serial_add_scheduler.sv
// Round-robin front end that time-shares one bit-serial adder among N requesters.
// Optional result backpressure (res_ready port) is enabled by defining SAS_BACKPRESSURE_EN.
module serial_add_scheduler #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic           res_valid,
    output logic [IDW-1:0] res_id,
    output logic [W-1:0]   res_sum,
    output logic           busy,
    output logic           sa_vld,
    output logic           sa_a,
    output logic           sa_b,
    output logic           sa_last,
    input  logic           sa_sum
`ifdef SAS_BACKPRESSURE_EN
    ,
    input  logic           res_ready
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] scan;
    logic           found;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   res_sh;
    logic [W-1:0]   sum_q;
    logic [CW-1:0]  cnt;
    logic           last_bit;
    logic           done_ack;

    // Serial sum bits enter at the MSB so the first (LSB) bit lands in bit 0 after W shifts.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] r, input logic b);
        logic [W:0] t;
        t = {b, r};
        return t[W:1];
    endfunction

    assign last_bit = (cnt == CNT_LAST);

`ifdef SAS_BACKPRESSURE_EN
    assign done_ack = res_ready;
`else
    assign done_ack = 1'b1;
`endif

    // Round-robin search starting at ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        grant = '0;
        scan  = '0;
        for (int k = 0; k < N; k++) begin
            scan = IDW'((int'(ptr) + k) % N);
            if (!found && req_valid[scan]) begin
                found = 1'b1;
                grant = scan;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IDW'(i)) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)    state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    if (done_ack) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            id     <= '0;
            id_q   <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            sum_q  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        a_sh <= sel_a;
                        b_sh <= sel_b;
                        id   <= grant;
                        ptr  <= (grant == ID_LAST) ? '0 : grant + IDW'(1);
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= shift_in(res_sh, sa_sum);
                    cnt    <= cnt + CW'(1);
                    // Result is latched separately so it survives the next operation's shifting.
                    if (last_bit) begin
                        sum_q <= shift_in(res_sh, sa_sum);
                        id_q  <= id;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        res_valid = 1'b0;
        busy      = 1'b0;
        sa_vld    = 1'b0;
        sa_a      = 1'b0;
        sa_b      = 1'b0;
        sa_last   = 1'b0;
        res_sum   = sum_q;
        res_id    = id_q;
        case (state)
            IDLE: begin
                for (int i = 0; i < N; i++) begin
                    req_ready[i] = found && !rst && (grant == IDW'(i));
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                sa_vld  = 1'b1;
                sa_a    = a_sh[0];
                sa_b    = b_sh[0];
                sa_last = last_bit;
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
